rv_decode_stage: RTL and testbench

Pipelined RV64IM instruction decode stage that converts a fetched 32-bit instruction into the operand-select and operation fields the execute-stage ALU consumes: 11-bit ALU opcode, 4-bit instruction type, sign-extended immediate, shift amount and register indices. It sits between fetch and execute. Input and output use valid/ready handshakes, with a two-entry skid buffer so that `in_ready` is driven from a flop. Illegal encodings are flagged and passed downstream, never dropped.

---
 rtl/rv_decode_pkg.sv | 122 ++++++++++++
 rtl/rv_decode_stage_skid.sv | 62 ++++++
 rtl/rv_decode_stage.sv | 159 +++++++++++++++
 tb/tb_rv_decode_stage.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// Shared definitions for the RV64IM decode stage: encodings, ALU op codes,
// the decoded-instruction record and immediate extraction helpers.
package rv_decode_pkg;

    localparam int PC_MAX_W = 64;

    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_OP_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'h1B;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_OP        = 7'h33;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_OP_32     = 7'h3B;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6F;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SR      = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;
    localparam logic [2:0] F3_MULH    = 3'd1;
    localparam logic [2:0] F3_MULHSU  = 3'd2;
    localparam logic [2:0] F3_MULHU   = 3'd3;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_MULDIV = 7'h01;
    localparam logic [6:0] F7_ALT    = 7'h20;

    typedef enum logic [3:0] {
        TYPE_NONE = 4'd0, RTYPE = 4'd1, ITYPE = 4'd2, STYPE = 4'd3,
        BTYPE = 4'd4, UTYPE = 4'd5, JTYPE = 4'd6
    } instr_type_e;

    typedef enum logic [10:0] {
        ALU_NOTHING = 11'd0,  ALU_ADD   = 11'd1,  ALU_SUB    = 11'd2,  ALU_SLL    = 11'd3,
        ALU_LESS    = 11'd4,  ALU_LESSU = 11'd5,  ALU_XOR    = 11'd6,  ALU_SRL    = 11'd7,
        ALU_SRA     = 11'd8,  ALU_OR    = 11'd9,  ALU_AND    = 11'd10, ALU_SLTIU  = 11'd11,
        ALU_MUL     = 11'd12, ALU_MULH  = 11'd13, ALU_MULHSU = 11'd14, ALU_MULHU  = 11'd15,
        ALU_DIV     = 11'd16, ALU_DIVU  = 11'd17, ALU_REM    = 11'd18, ALU_REMU   = 11'd19,
        ALU_EQUAL   = 11'd20, ALU_NEQ   = 11'd21, ALU_GTE    = 11'd22, ALU_GTEU   = 11'd23,
        ALU_IMMVAL  = 11'd24
    } alu_op_e;

    typedef struct packed {
        alu_op_e               opcode;
        instr_type_e           instr_type;
        logic [31:0]           immediate;
        logic [5:0]            shamt;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic                  word;
        logic                  illegal;
        logic [PC_MAX_W-1:0]   pc;
    } decoded_t;

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // alt selects SUB over ADD and SRA over SRL
    function automatic alu_op_e base_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_LESS;
            3'd3:    return ALU_LESSU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e muldiv_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_MUL;
            3'd1:    return ALU_MULH;
            3'd2:    return ALU_MULHSU;
            3'd3:    return ALU_MULHU;
            3'd4:    return ALU_DIV;
            3'd5:    return ALU_DIVU;
            3'd6:    return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

    function automatic alu_op_e branch_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_EQUAL;
            3'd1:    return ALU_NEQ;
            3'd4:    return ALU_LESS;
            3'd5:    return ALU_GTE;
            3'd6:    return ALU_LESSU;
            3'd7:    return ALU_GTEU;
            default: return ALU_NOTHING;
        endcase
    endfunction

endpackage

// File: rtl/rv_decode_stage_skid.sv
// Generic two-entry valid/ready skid buffer with flush; in_ready comes
// straight from a flop so the upstream path is not combinational.
module rv_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         head_valid_r;
    logic         skid_valid_r;
    logic         in_ready_r;
    logic [W-1:0] head_data_r;
    logic [W-1:0] skid_data_r;
    logic         accept_s;
    logic         head_free_s;

    // Handshake qualifiers for this cycle
    always_comb begin
        accept_s    = in_valid && in_ready_r;
        head_free_s = !head_valid_r || out_ready;
    end

    // Head/skid state; in_ready_r is always the inverse of the next skid state
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            head_data_r  <= '0;
            skid_data_r  <= '0;
        end else if (head_free_s) begin
            if (skid_valid_r) begin
                head_valid_r <= 1'b1;
                head_data_r  <= skid_data_r;
            end else if (accept_s) begin
                head_valid_r <= 1'b1;
                head_data_r  <= in_data;
            end else begin
                head_valid_r <= 1'b0;
            end
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else if (accept_s) begin
            skid_valid_r <= 1'b1;
            skid_data_r  <= in_data;
            in_ready_r   <= 1'b0;
        end else begin
            in_ready_r   <= !skid_valid_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = head_valid_r;
    assign out_data  = head_data_r;
endmodule

// File: rtl/rv_decode_stage.sv
// RV64IM decode stage: combinational decode of the fetched word feeding a
// two-entry skid buffer whose head register drives the execute interface.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [10:0]     out_opcode,
    output logic [3:0]      out_instr_type,
    output logic [31:0]     out_immediate,
    output logic [5:0]      out_shamt,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_word,
    output logic            out_illegal,
    output logic [PC_W-1:0] out_pc
);
    decoded_t dec_s;
    decoded_t head_s;

    function automatic decoded_t decode_instr(input logic [31:0] instr);
        decoded_t   d;
        logic [6:0] major;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       is_word;
        logic       legal;
        d       = '0;
        major   = instr[6:0];
        f3      = instr[14:12];
        f7      = instr[31:25];
        is_word = (major == OPC_OP_32) || (major == OPC_OP_IMM_32);
        legal   = 1'b1;
        d.word  = is_word;
        case (major)
            OPC_OP, OPC_OP_32: begin
                d.instr_type = RTYPE;
                d.rs1 = instr[19:15];
                d.rs2 = instr[24:20];
                d.rd  = instr[11:7];
                if (f7 == F7_MULDIV) begin
                    d.opcode = muldiv_op(f3);
                    legal = !is_word || !(f3 inside {F3_MULH, F3_MULHSU, F3_MULHU});
                end else if (f7 == F7_BASE || f7 == F7_ALT) begin
                    d.opcode = base_op(f3, f7[5]);
                    legal = (f7 == F7_BASE || f3 == F3_ADD_SUB || f3 == F3_SR) &&
                            (!is_word || f3 inside {F3_ADD_SUB, F3_SLL, F3_SR});
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                d.instr_type = ITYPE;
                d.rs1 = instr[19:15];
                d.rd  = instr[11:7];
                d.immediate = imm_i(instr);
                if (f3 == F3_SLL || f3 == F3_SR) begin
                    // 6-bit shamt; the W forms only have 5 bits of shift range
                    d.shamt  = instr[25:20];
                    d.opcode = base_op(f3, instr[30]);
                    legal = (instr[31:26] == 6'b000000 ||
                             (f3 == F3_SR && instr[31:26] == 6'b010000)) &&
                            !(is_word && instr[25]);
                end else begin
                    d.opcode = (f3 == F3_SLTU) ? ALU_SLTIU : base_op(f3, 1'b0);
                    legal = !is_word || f3 == F3_ADD_SUB;
                end
            end
            OPC_LOAD, OPC_JALR: begin
                d.instr_type = ITYPE;
                d.opcode = ALU_ADD;
                d.rs1 = instr[19:15];
                d.rd  = instr[11:7];
                d.immediate = imm_i(instr);
                legal = (major == OPC_LOAD) ? (f3 != 3'd7) : (f3 == 3'd0);
            end
            OPC_STORE: begin
                d.instr_type = STYPE;
                d.opcode = ALU_ADD;
                d.rs1 = instr[19:15];
                d.rs2 = instr[24:20];
                d.immediate = imm_s(instr);
                legal = !f3[2];
            end
            OPC_BRANCH: begin
                d.instr_type = BTYPE;
                d.opcode = branch_op(f3);
                d.rs1 = instr[19:15];
                d.rs2 = instr[24:20];
                d.immediate = imm_b(instr);
                legal = (f3[2:1] != 2'b01);
            end
            OPC_LUI, OPC_AUIPC: begin
                d.instr_type = UTYPE;
                d.opcode = ALU_IMMVAL;
                d.rd = instr[11:7];
                d.immediate = imm_u(instr);
            end
            OPC_JAL: begin
                d.instr_type = JTYPE;
                d.opcode = ALU_ADD;
                d.rd = instr[11:7];
                d.immediate = imm_j(instr);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        if (!legal) begin
            d = '0;
            d.illegal = 1'b1;
            d.opcode  = ALU_NOTHING;
        end else begin
            d.illegal = 1'b0;
        end
        return d;
    endfunction

    // Decode the offered word and tag it with its address
    always_comb begin
        dec_s    = decode_instr(in_instr);
        dec_s.pc = PC_MAX_W'(in_pc);
    end

    rv_skid_buffer #(
        .W($bits(decoded_t))
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (dec_s),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head_s)
    );

    assign out_opcode     = head_s.opcode;
    assign out_instr_type = head_s.instr_type;
    assign out_immediate  = head_s.immediate;
    assign out_shamt      = head_s.shamt;
    assign out_rs1        = head_s.rs1;
    assign out_rs2        = head_s.rs2;
    assign out_rd         = head_s.rd;
    assign out_word       = head_s.word;
    assign out_illegal    = head_s.illegal;
    assign out_pc         = head_s.pc[PC_W-1:0];
endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage: directed test-plan cases plus
// randomized traffic checked against a table-driven decode model and an
// occupancy-queue model of the two-entry buffer.
module tb_rv_decode_stage;
    import rv_decode_pkg::*;

    typedef struct packed {
        logic [10:0] op;
        logic [3:0]  typ;
        logic [31:0] imm;
        logic [5:0]  shamt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        word;
        logic        illegal;
        logic [63:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'h0;
    logic [63:0] in_pc = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_opcode;
    logic [3:0]  out_instr_type;
    logic [31:0] out_immediate;
    logic [5:0]  out_shamt;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic        out_word, out_illegal;
    logic [63:0] out_pc;
    logic [133:0] obs;

    int tests_run = 0;
    int tests_failed = 0;
    exp_t q[$];
    logic [14:0] tbl [logic [18:0]];
    logic [6:0] majors [11] = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                                7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F};

    rv_decode_stage #(.PC_W(64)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_instr_type(out_instr_type), .out_immediate(out_immediate),
        .out_shamt(out_shamt), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_word(out_word), .out_illegal(out_illegal), .out_pc(out_pc)
    );

    assign obs = {out_opcode, out_instr_type, out_immediate, out_shamt,
                  out_rs1, out_rs2, out_rd, out_word, out_illegal, out_pc};

    always #5 clk = ~clk;

    // ---------------- reference decode: legal encodings as a lookup table
    task automatic add(input logic [6:0] op, input int f3, input int f7,
                       input logic [10:0] alu, input logic [3:0] ty);
        logic [3:0] k3;
        logic [7:0] k7;
        k3 = (f3 < 0) ? 4'h8 : {1'b0, 3'(f3)};
        k7 = (f7 < 0) ? 8'h80 : {1'b0, 7'(f7)};
        tbl[{op, k3, k7}] = {alu, ty};
    endtask

    task automatic build_table();
        logic [10:0] base_ops [8];
        logic [10:0] md_ops [8];
        logic [10:0] br_ops [8];
        base_ops = '{ALU_ADD, ALU_SLL, ALU_LESS, ALU_LESSU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        md_ops   = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        br_ops   = '{ALU_EQUAL, ALU_NEQ, ALU_NOTHING, ALU_NOTHING, ALU_LESS, ALU_GTE, ALU_LESSU, ALU_GTEU};
        for (int f = 0; f < 8; f++) begin
            add(7'h33, f, 0, base_ops[f], RTYPE);
            add(7'h33, f, 1, md_ops[f], RTYPE);
            if (f == 0 || f >= 4) add(7'h3B, f, 1, md_ops[f], RTYPE);
            if (f == 0 || f == 1 || f == 5) add(7'h3B, f, 0, base_ops[f], RTYPE);
            if (f != 1 && f != 5) add(7'h13, f, -1, (f == 3) ? 11'(ALU_SLTIU) : base_ops[f], ITYPE);
            if (f != 7) add(7'h03, f, -1, ALU_ADD, ITYPE);
            if (f < 4) add(7'h23, f, -1, ALU_ADD, STYPE);
            if (f != 2 && f != 3) add(7'h63, f, -1, br_ops[f], BTYPE);
        end
        add(7'h33, 0, 7'h20, ALU_SUB, RTYPE);  add(7'h33, 5, 7'h20, ALU_SRA, RTYPE);
        add(7'h3B, 0, 7'h20, ALU_SUB, RTYPE);  add(7'h3B, 5, 7'h20, ALU_SRA, RTYPE);
        add(7'h13, 1, 7'h00, ALU_SLL, ITYPE);  add(7'h13, 1, 7'h01, ALU_SLL, ITYPE);
        add(7'h13, 5, 7'h00, ALU_SRL, ITYPE);  add(7'h13, 5, 7'h01, ALU_SRL, ITYPE);
        add(7'h13, 5, 7'h20, ALU_SRA, ITYPE);  add(7'h13, 5, 7'h21, ALU_SRA, ITYPE);
        add(7'h1B, 0, -1, ALU_ADD, ITYPE);     add(7'h1B, 1, 7'h00, ALU_SLL, ITYPE);
        add(7'h1B, 5, 7'h00, ALU_SRL, ITYPE);  add(7'h1B, 5, 7'h20, ALU_SRA, ITYPE);
        add(7'h67, 0, -1, ALU_ADD, ITYPE);
        add(7'h37, -1, -1, ALU_IMMVAL, UTYPE); add(7'h17, -1, -1, ALU_IMMVAL, UTYPE);
        add(7'h6F, -1, -1, ALU_ADD, JTYPE);
    endtask

    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [63:0] pc);
        exp_t e;
        logic [6:0] op;
        logic [18:0] k_exact, k_f7any, k_any;
        logic [14:0] v;
        op = ins[6:0];
        k_exact = {op, 1'b0, ins[14:12], 1'b0, ins[31:25]};
        k_f7any = {op, 1'b0, ins[14:12], 8'h80};
        k_any   = {op, 4'h8, 8'h80};
        e = '0;
        e.pc = pc;
        if (tbl.exists(k_exact)) v = tbl[k_exact];
        else if (tbl.exists(k_f7any)) v = tbl[k_f7any];
        else if (tbl.exists(k_any)) v = tbl[k_any];
        else begin
            e.illegal = 1'b1;
            return e;
        end
        e.op  = v[14:4];
        e.typ = v[3:0];
        e.word = (op == 7'h1B || op == 7'h3B);
        if (e.typ == RTYPE || e.typ == ITYPE || e.typ == STYPE || e.typ == BTYPE) e.rs1 = ins[19:15];
        if (e.typ == RTYPE || e.typ == STYPE || e.typ == BTYPE) e.rs2 = ins[24:20];
        if (e.typ == RTYPE || e.typ == ITYPE || e.typ == UTYPE || e.typ == JTYPE) e.rd = ins[11:7];
        case (e.typ)
            ITYPE: e.imm = 32'($signed(ins) >>> 20);
            STYPE: e.imm = (32'($signed(ins) >>> 20) & ~32'h1F) | ((ins >> 7) & 32'h1F);
            BTYPE: e.imm = (32'($signed(ins) >>> 19) & 32'hFFFFF000) | ((ins << 4) & 32'h800) |
                           ((ins >> 20) & 32'h7E0) | ((ins >> 7) & 32'h1E);
            UTYPE: e.imm = ins & 32'hFFFFF000;
            JTYPE: e.imm = (32'($signed(ins) >>> 11) & 32'hFFF00000) | (ins & 32'h000FF000) |
                           ((ins >> 9) & 32'h800) | ((ins >> 20) & 32'h7FE);
            default: e.imm = 32'h0;
        endcase
        if ((op == 7'h13 || op == 7'h1B) && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5))
            e.shamt = ins[25:20];
        return e;
    endfunction

    function automatic exp_t mk(input logic [10:0] op, input logic [3:0] ty, input logic [31:0] imm,
                                input logic [5:0] sh, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rd, input logic ill, input logic [63:0] pc);
        exp_t e;
        e = '{op: op, typ: ty, imm: imm, shamt: sh, rs1: r1, rs2: r2, rd: rd,
              word: 1'b0, illegal: ill, pc: pc};
        return e;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) < 8) w[6:0] = majors[$urandom_range(0, 10)];
        case ($urandom_range(0, 4))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            3: w[31:25] = 7'h21;
            default: w[31:25] = w[31:25];
        endcase
        return w;
    endfunction

    // One clock: track occupancy and contents of the stage as an ordered queue
    task automatic cycle();
        logic acc, drn;
        exp_t e;
        acc = in_valid && (q.size() < 2);
        drn = out_ready && (q.size() > 0);
        e = ref_decode(in_instr, in_pc);
        @(posedge clk);
        if (reset || flush) q.delete();
        else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tests_run++; if (obs !== 134'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", obs); end
    endtask

    task automatic test_decode_directed();
        logic [31:0] ins [5];
        exp_t ex [5];
        ins[0] = 32'h00500093; ex[0] = mk(ALU_ADD, ITYPE, 32'd5, 6'd0, 5'd0, 5'd0, 5'd1, 1'b0, 64'h1000);
        ins[1] = 32'h40715193; ex[1] = mk(ALU_SRA, ITYPE, 32'h407, 6'd7, 5'd2, 5'd0, 5'd3, 1'b0, 64'h1004);
        ins[2] = 32'h123450B7; ex[2] = mk(ALU_IMMVAL, UTYPE, 32'h12345000, 6'd0, 5'd0, 5'd0, 5'd1, 1'b0, 64'h1008);
        ins[3] = 32'hFE208EE3; ex[3] = mk(ALU_EQUAL, BTYPE, 32'hFFFFFFFC, 6'd0, 5'd1, 5'd2, 5'd0, 1'b0, 64'h100C);
        ins[4] = 32'hFFFFFFFF; ex[4] = mk(ALU_NOTHING, TYPE_NONE, 32'h0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b1, 64'h1010);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_instr = ins[i];
            in_pc = 64'h1000 + 64'(4 * i);
            cycle();
            in_valid = 1'b0;
            tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL directed%0d_valid: got %b expected 1", i, out_valid); end
            tests_run++; if (obs !== ex[i]) begin tests_failed++; $display("FAIL directed%0d_fields: got %h expected %h", i, obs, ex[i]); end
            cycle();
        end
    endtask

    task automatic test_skid();
        exp_t sub_e, add_e;
        sub_e = mk(ALU_SUB, RTYPE, 32'h0, 6'd0, 5'd6, 5'd7, 5'd5, 1'b0, 64'h2000);
        add_e = mk(ALU_ADD, ITYPE, 32'd5, 6'd0, 5'd0, 5'd0, 5'd1, 1'b0, 64'h2004);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h407302B3; in_pc = 64'h2000;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (obs !== sub_e || out_valid !== 1'b1) begin tests_failed++; $display("FAIL skid_hold%0d: got %b/%h expected 1/%h", i, out_valid, obs, sub_e); end
            cycle();
        end
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h2004;
        cycle();
        in_instr = 32'h00100113; in_pc = 64'h2008;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL skid_full_in_ready: got %b expected 0", in_ready); end
        tests_run++; if (obs !== sub_e) begin tests_failed++; $display("FAIL skid_full_head: got %h expected %h", obs, sub_e); end
        cycle();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tests_run++; if (obs !== sub_e) begin tests_failed++; $display("FAIL skid_drain_first: got %h expected %h", obs, sub_e); end
        cycle();
        tests_run++; if (obs !== add_e || out_valid !== 1'b1) begin tests_failed++; $display("FAIL skid_drain_second: got %b/%h expected 1/%h", out_valid, obs, add_e); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL skid_drain_in_ready: got %b expected 1", in_ready); end
        cycle();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL skid_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [8];
        logic [63:0] pcs [8];
        int n_out = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ins[i] = gen_instr();
            pcs[i] = {$urandom, $urandom};
            in_valid = 1'b1; in_instr = ins[i]; in_pc = pcs[i];
            cycle();
            if (out_valid === 1'b1) n_out++;
            tests_run++; if (obs !== ref_decode(ins[i], pcs[i]) || out_valid !== 1'b1) begin
                tests_failed++; $display("FAIL b2b%0d: got %b/%h expected 1/%h", i, out_valid, obs, ref_decode(ins[i], pcs[i]));
            end
        end
        in_valid = 1'b0;
        tests_run++; if (n_out != 8) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 8", n_out); end
        cycle();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_tail: got %b expected 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h3000;
        cycle();
        in_instr = 32'h407302B3; in_pc = 64'h3004;
        cycle();
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_prefull: got %b expected 0", in_ready); end
        flush = 1'b1; in_instr = 32'h123450B7; in_pc = 64'h3008;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_full_valid: got %b expected 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_full_in_ready: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        cycle();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_full_after: got %b expected 0", out_valid); end
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h3010;
        cycle();
        flush = 1'b1; in_instr = 32'hFE208EE3; in_pc = 64'h3014;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_accept_valid: got %b expected 0", out_valid); end
        out_ready = 1'b1;
        cycle();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_accept_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h4000;
        cycle();
        in_instr = 32'h40715193; in_pc = 64'h4004;
        cycle();
        reset = 1'b1; out_ready = 1'b1;
        cycle();
        reset = 1'b0; in_valid = 1'b0;
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_stall_valid: got %b expected 0", out_valid); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_stall_in_ready: got %b expected 1", in_ready); end
        tests_run++; if (obs !== 134'h0) begin tests_failed++; $display("FAIL rst_stall_data: got %h expected 0", obs); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_instr  = gen_instr();
            in_pc     = {$urandom, $urandom};
            cycle();
            tests_run++; if (out_valid !== (q.size() > 0)) begin tests_failed++; $display("FAIL rand%0d_valid: got %b expected %b", i, out_valid, q.size() > 0); end
            tests_run++; if (in_ready !== (q.size() < 2)) begin tests_failed++; $display("FAIL rand%0d_in_ready: got %b expected %b", i, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                tests_run++; if (obs !== q[0]) begin tests_failed++; $display("FAIL rand%0d_fields: got %h expected %h", i, obs, q[0]); end
            end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        build_table();
        test_reset();
        test_decode_directed();
        test_skid();
        test_back_to_back();
        test_flush();
        test_reset_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
